int8_zero_skip_pair_feeder: RTL and testbench



---
 rtl/int8_zero_skip_pair_feeder.sv | 192 +++++++++++++++++++
 tb/tb_int8_zero_skip_pair_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int8_zero_skip_pair_feeder.sv
// Zero-skip compactor feeding the dual-lane int8 MAC: CLEAR, RUN, optional FLUSH, TERM per vector.
// Define FEEDER_STATS_EN to expose the per-vector skip count (stat_skip_count / stat_valid).
module int8_zero_skip_pair_feeder #(
  parameter int unsigned CNT_WIDTH        = 16,
  parameter bit          SKIP_ZERO_WEIGHT = 1'b1,
  parameter bit          SKIP_ZERO_ACT    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_weight0,
  input  logic [7:0]           s_act0,
  input  logic [7:0]           s_weight1,
  input  logic [7:0]           s_act1,
  input  logic                 s_keep1,
  input  logic                 s_last,
  output logic                 clear_acc,
  output logic                 valid0,
  output logic                 valid1,
  output logic                 last0,
  output logic                 last1,
  output logic [7:0]           weight0,
  output logic [7:0]           weight1,
  output logic [7:0]           act0,
  output logic [7:0]           act1
`ifdef FEEDER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_skip_count,
  output logic                 stat_valid
`endif
);

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_FLUSH, ST_TERM} state_t;

  state_t               r_state, w_next;
  logic [15:0]          r_held;
  logic                 r_held_v;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_accept, w_surv0, w_surv1;
  logic [15:0]          w_e0, w_e1;
  logic [15:0]          w_cand [3];
  logic [1:0]           w_ncand;
  logic [1:0]           w_drop;
  logic [CNT_WIDTH:0]   w_cnt_sum;

  logic                 w_ready_d, w_clear_d, w_v0_d, w_v1_d, w_last0_d;
  logic [15:0]          w_lane0_d, w_lane1_d, w_held_d;
  logic                 w_held_v_d;
  logic [CNT_WIDTH-1:0] w_cnt_d;

  function automatic logic survives(input logic [7:0] w, input logic [7:0] a);
    return !((SKIP_ZERO_WEIGHT && (w == 8'd0)) || (SKIP_ZERO_ACT && (a == 8'd0)));
  endfunction

  // Candidate list in arrival order: held element first, then element 0, then element 1.
  always_comb begin
    w_e0      = {s_weight0, s_act0};
    w_e1      = {s_weight1, s_act1};
    w_surv0   = survives(s_weight0, s_act0);
    w_surv1   = s_keep1 && survives(s_weight1, s_act1);
    w_drop    = {1'b0, !w_surv0} + {1'b0, s_keep1 && !w_surv1};
    w_cnt_sum = {1'b0, r_cnt} + {{(CNT_WIDTH-1){1'b0}}, w_drop};
    w_cand[0] = '0;
    w_cand[1] = '0;
    w_cand[2] = '0;
    w_ncand   = 2'd0;
    if (r_held_v) begin
      w_cand[0] = r_held;
      w_ncand   = 2'd1;
    end
    if (w_surv0) begin
      if (r_held_v) w_cand[1] = w_e0;
      else          w_cand[0] = w_e0;
      w_ncand = w_ncand + 2'd1;
    end
    if (w_surv1) begin
      case (w_ncand)
        2'd0:    w_cand[0] = w_e1;
        2'd1:    w_cand[1] = w_e1;
        default: w_cand[2] = w_e1;
      endcase
      w_ncand = w_ncand + 2'd1;
    end
  end

  assign w_accept = (r_state == ST_RUN) && s_ready && s_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ready_d  = 1'b0;
    w_clear_d  = 1'b0;
    w_v0_d     = 1'b0;
    w_v1_d     = 1'b0;
    w_last0_d  = 1'b0;
    w_lane0_d  = '0;
    w_lane1_d  = '0;
    w_held_d   = r_held;
    w_held_v_d = r_held_v;
    w_cnt_d    = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_clear_d  = 1'b1;
        w_held_v_d = 1'b0;
        w_next     = ST_RUN;
      end
      ST_RUN: begin
        // s_ready is registered, so it rises one cycle after entering RUN.
        w_ready_d = 1'b1;
        if (w_accept) begin
          w_cnt_d = w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];
          if (w_ncand >= 2'd2) begin
            w_v0_d     = 1'b1;
            w_v1_d     = 1'b1;
            w_lane0_d  = w_cand[0];
            w_lane1_d  = w_cand[1];
            w_held_d   = w_cand[2];
            w_held_v_d = (w_ncand == 2'd3);
          end else begin
            w_held_d   = w_cand[0];
            w_held_v_d = (w_ncand == 2'd1);
          end
          if (s_last) begin
            w_ready_d = 1'b0;
            w_next    = w_held_v_d ? ST_FLUSH : ST_TERM;
          end
        end
      end
      ST_FLUSH: begin
        w_v0_d     = 1'b1;
        w_lane0_d  = r_held;
        w_held_v_d = 1'b0;
        w_next     = ST_TERM;
      end
      default: begin
        w_v0_d    = 1'b1;
        w_last0_d = 1'b1;
        w_cnt_d   = '0;
        w_next    = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready   <= 1'b0;
      clear_acc <= 1'b0;
      valid0    <= 1'b0;
      valid1    <= 1'b0;
      last0     <= 1'b0;
      last1     <= 1'b0;
      weight0   <= '0;
      act0      <= '0;
      weight1   <= '0;
      act1      <= '0;
      r_held    <= '0;
      r_held_v  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      s_ready           <= w_ready_d;
      clear_acc         <= w_clear_d;
      valid0            <= w_v0_d;
      valid1            <= w_v1_d;
      last0             <= w_last0_d;
      last1             <= 1'b0;
      {weight0, act0}   <= w_lane0_d;
      {weight1, act1}   <= w_lane1_d;
      r_held            <= w_held_d;
      r_held_v          <= w_held_v_d;
      r_cnt             <= w_cnt_d;
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_skip_count <= '0;
      stat_valid      <= 1'b0;
    end else begin
      stat_valid <= (r_state == ST_TERM);
      if (r_state == ST_TERM) stat_skip_count <= r_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_int8_zero_skip_pair_feeder.sv
// Bench for int8_zero_skip_pair_feeder: directed table, corner sequences and random vectors
// against a list-level reference model plus a MAC emulation on the output stream.
module tb_int8_zero_skip_pair_feeder;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0, s_keep1 = 1'b1, s_last = 1'b0;
  logic [7:0] s_weight0 = '0, s_act0 = '0, s_weight1 = '0, s_act1 = '0;
  logic s_ready, clear_acc, valid0, valid1, last0, last1;
  logic [7:0] weight0, weight1, act0, act1;
`ifdef FEEDER_STATS_EN
  logic [CW-1:0] stat_skip_count;
  logic          stat_valid;
`endif

  always #5 clk = ~clk;

  int8_zero_skip_pair_feeder #(.CNT_WIDTH(CW), .SKIP_ZERO_WEIGHT(1'b1), .SKIP_ZERO_ACT(1'b1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_weight0(s_weight0), .s_act0(s_act0), .s_weight1(s_weight1), .s_act1(s_act1),
    .s_keep1(s_keep1), .s_last(s_last), .clear_acc(clear_acc),
    .valid0(valid0), .valid1(valid1), .last0(last0), .last1(last1),
    .weight0(weight0), .weight1(weight1), .act0(act0), .act1(act1)
`ifdef FEEDER_STATS_EN
    , .stat_skip_count(stat_skip_count), .stat_valid(stat_valid)
`endif
  );

  typedef struct {
    logic [7:0] w0, a0, w1, a1;
    bit         keep1;
    int         gap;
  } beat_t;

  typedef struct {
    string name;
    int    nb;
    beat_t b0, b1;
    int    acc, skip;
  } tcase_t;

  beat_t       cur_vec[$];
  logic [35:0] exp_q[$], obs_q[$];
  int          mac_q[$], stat_q[$];
  int          viol = 0;
  int          n_pass = 0, n_total = 0;
  int          mac_acc = 0;

  function automatic logic [35:0] mk(bit c, bit v0, bit v1, bit l0,
                                     logic [7:0] w0, logic [7:0] a0, logic [7:0] w1, logic [7:0] a1);
    return {c, v0, v1, l0, w0, a0, w1, a1};
  endfunction

  function automatic beat_t bt(logic [7:0] w0, logic [7:0] a0, logic [7:0] w1, logic [7:0] a1,
                               bit keep1, int gap);
    beat_t b;
    b.w0 = w0; b.a0 = a0; b.w1 = w1; b.a1 = a1; b.keep1 = keep1; b.gap = gap;
    return b;
  endfunction

  function automatic logic [7:0] rnd_val();
    logic [7:0] v;
    v = 8'($urandom);
    return ($urandom % 3 == 0) ? 8'h00 : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: records every non-idle output cycle and emulates the downstream MAC.
  always @(negedge clk) begin
    if (clear_acc || valid0 || valid1)
      obs_q.push_back(mk(clear_acc, valid0, valid1, last0,
                         valid0 ? weight0 : 8'h00, valid0 ? act0 : 8'h00,
                         valid1 ? weight1 : 8'h00, valid1 ? act1 : 8'h00));
    if (clear_acc && (valid0 || valid1)) viol++;
    if (last1) viol++;
    if (last0 && !valid0) viol++;
    if (clear_acc) mac_acc = 0;
    if (valid0) mac_acc = mac_acc + $signed(weight0) * $signed(act0);
    if (valid1) mac_acc = mac_acc + $signed(weight1) * $signed(act1);
    if (valid0 && last0) mac_q.push_back(mac_acc);
`ifdef FEEDER_STATS_EN
    if (stat_valid) begin
      stat_q.push_back(int'(stat_skip_count));
      if (!(valid0 && last0)) viol++;
    end
`endif
  end

  // Reference: flatten the vector, filter survivors, pair them in order, odd tail, terminator, clear.
  task automatic model(output int acc, output int skip);
    logic [15:0] surv[$];
    int drops;
    drops = 0;
    acc   = 0;
    foreach (cur_vec[i]) begin
      for (int e = 0; e < 2; e++) begin
        logic [7:0] w, a;
        w = (e == 0) ? cur_vec[i].w0 : cur_vec[i].w1;
        a = (e == 0) ? cur_vec[i].a0 : cur_vec[i].a1;
        if (e == 1 && !cur_vec[i].keep1) continue;
        if (w == 8'd0 || a == 8'd0) drops++;
        else begin
          surv.push_back({w, a});
          acc = acc + $signed(w) * $signed(a);
        end
      end
    end
    for (int i = 0; i + 1 < surv.size(); i += 2)
      exp_q.push_back(mk(0, 1, 1, 0, surv[i][15:8], surv[i][7:0], surv[i+1][15:8], surv[i+1][7:0]));
    if (surv.size() % 2 == 1)
      exp_q.push_back(mk(0, 1, 0, 0, surv[surv.size()-1][15:8], surv[surv.size()-1][7:0], 8'h00, 8'h00));
    exp_q.push_back(mk(0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00));
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00));
    skip = (drops > (2**CW - 1)) ? (2**CW - 1) : drops;
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_beat(input beat_t b, input bit last);
    repeat (b.gap) @(negedge clk);
    s_valid = 1'b1; s_last = last; s_keep1 = b.keep1;
    s_weight0 = b.w0; s_act0 = b.a0; s_weight1 = b.w1; s_act1 = b.a1;
    for (int i = 0; i < 40 && !s_ready; i++) @(negedge clk);
    if (!s_ready) check("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_vec();
    foreach (cur_vec[i]) send_beat(cur_vec[i], i == cur_vec.size() - 1);
  endtask

  task automatic finish_vec(input string tag, input int e_acc, input int e_skip, input bit has_term);
    logic [35:0] e, o;
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    check({tag, " stream_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      check({tag, " beat"}, 64'(o), 64'(e));
    end
    obs_q.delete();
    if (has_term) begin
      check({tag, " mac_acc"}, (mac_q.size() > 0) ? 64'(mac_q.pop_front()) : 64'hdead, 64'(e_acc));
`ifdef FEEDER_STATS_EN
      check({tag, " skip_count"}, (stat_q.size() > 0) ? 64'(stat_q.pop_front()) : 64'hdead, 64'(e_skip));
`endif
    end else begin
      check({tag, " no_term"}, 64'(mac_q.size() + stat_q.size()), 64'd0);
    end
    mac_q.delete();
    stat_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tcase_t tbl[5];
    int ma, ms, nb;
    beat_t b;

    tbl[0].name = "plan_a";   tbl[0].nb = 2; tbl[0].acc = 2;     tbl[0].skip = 2;
    tbl[0].b0 = bt(8'd3, 8'd2, 8'd0, 8'd5, 1, 0);
    tbl[0].b1 = bt(8'd4, 8'hFF, 8'd2, 8'd0, 1, 0);
    tbl[1].name = "plan_odd"; tbl[1].nb = 2; tbl[1].acc = 14;    tbl[1].skip = 0;
    tbl[1].b0 = bt(8'd1, 8'd1, 8'd2, 8'd2, 1, 0);
    tbl[1].b1 = bt(8'd3, 8'd3, 8'd0, 8'd0, 0, 0);
    tbl[2].name = "all_zero"; tbl[2].nb = 1; tbl[2].acc = 0;     tbl[2].skip = 2;
    tbl[2].b0 = bt(8'd0, 8'd7, 8'd5, 8'd0, 1, 0);
    tbl[2].b1 = bt(8'd0, 8'd0, 8'd0, 8'd0, 1, 0);
    tbl[3].name = "gaps";     tbl[3].nb = 2; tbl[3].acc = -13;   tbl[3].skip = 1;
    tbl[3].b0 = bt(8'd2, 8'd3, 8'd0, 8'd0, 1, 0);
    tbl[3].b1 = bt(8'hFC, 8'd5, 8'd1, 8'd1, 1, 3);
    tbl[4].name = "single";   tbl[4].nb = 1; tbl[4].acc = 16384; tbl[4].skip = 0;
    tbl[4].b0 = bt(8'h80, 8'h80, 8'd0, 8'd0, 0, 0);
    tbl[4].b1 = bt(8'd0, 8'd0, 8'd0, 8'd0, 1, 0);

    repeat (3) @(negedge clk);
    check("reset_outputs", {s_ready, clear_acc, valid0, valid1, last0, last1,
                            weight0, act0, weight1, act1}, 64'd0);
`ifdef FEEDER_STATS_EN
    check("reset_stats", {stat_valid, stat_skip_count}, 64'd0);
`endif
    rst = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    check("rst_cycle1", {clear_acc, s_ready, valid0, valid1}, 64'b1000);
    @(negedge clk);
    check("rst_cycle2", {clear_acc, s_ready, valid0, valid1}, 64'b0100);

    for (int t = 0; t < 5; t++) begin
      cur_vec.delete();
      cur_vec.push_back(tbl[t].b0);
      if (tbl[t].nb > 1) cur_vec.push_back(tbl[t].b1);
      model(ma, ms);
      send_vec();
      finish_vec(tbl[t].name, tbl[t].acc, tbl[t].skip, 1);
    end

    // One-cycle latency and TERM/CLEAR sequencing for an even-survivor vector.
    cur_vec.delete();
    cur_vec.push_back(bt(8'd5, 8'd5, 8'd6, 8'd6, 1, 0));
    model(ma, ms);
    send_beat(cur_vec[0], 1);
    check("lat_pair", {valid0, valid1, last0}, 64'b110);
    @(negedge clk);
    check("lat_term", {valid0, valid1, last0, s_ready}, 64'b1010);
    @(negedge clk);
    check("lat_clear", {clear_acc, s_ready, valid0}, 64'b100);
    finish_vec("lat", 61, 0, 1);

    // Skip counter saturation: 20 dropped elements into a 4-bit counter.
    cur_vec.delete();
    repeat (10) cur_vec.push_back(bt(8'd0, 8'd3, 8'd9, 8'd0, 1, 0));
    model(ma, ms);
    send_vec();
    finish_vec("saturate", 0, 15, 1);

    // Reset while FLUSH is pending: the held (3,3) must never appear.
    cur_vec.delete();
    cur_vec.push_back(bt(8'd1, 8'd1, 8'd2, 8'd2, 1, 0));
    cur_vec.push_back(bt(8'd3, 8'd3, 8'd0, 8'd0, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0, 8'd1, 8'd1, 8'd2, 8'd2));
    send_vec();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_zero", {s_ready, clear_acc, valid0, valid1, last0, last1,
                          weight0, act0, weight1, act1}, 64'd0);
    rst = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    check("rstmid_clear", {clear_acc, valid0, valid1, s_ready}, 64'b1000);
    finish_vec("rstmid", 0, 0, 0);

    for (int v = 0; v < 150; v++) begin
      nb = 1 + int'($urandom % 5);
      cur_vec.delete();
      for (int i = 0; i < nb; i++) begin
        b.w0 = rnd_val(); b.a0 = rnd_val(); b.w1 = rnd_val(); b.a1 = rnd_val();
        b.keep1 = (i == nb - 1) ? bit'($urandom % 2) : 1'b1;
        b.gap   = ($urandom % 4 == 0) ? int'($urandom % 4) : 0;
        cur_vec.push_back(b);
      end
      model(ma, ms);
      send_vec();
      finish_vec("random", ma, ms, 1);
    end

    check("invariants", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
